// File: rtl/alu_arbiter.sv
// alu_arbiter: two request ports share one external combinational ALU.
// One operation is in flight at a time: IDLE (accept) -> EXEC (ALU evaluates
// the latched operands) -> RESP (result held until the granted port takes it).
module alu_arbiter #(
   parameter bit RR_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [3:0]  req0_ctr,
   output logic        resp0_valid,
   input  logic        resp0_ready,
   output logic [31:0] resp0_out,

   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [3:0]  req1_ctr,
   output logic        resp1_valid,
   input  logic        resp1_ready,
   output logic [31:0] resp1_out,

   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_ctr,
   input  logic [31:0] alu_out,

   output logic        busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      state_q;
   logic [31:0] a_q, b_q, res_q;
   logic [3:0]  ctr_q;
   logic        grant_q;   // port owning the in-flight operation
   logic        last_q;    // port granted on the most recent acceptance
   logic        grant_d;
   logic        accept;
   logic        resp_take;

   // Pick the port to serve this cycle: a lone requester wins, a tie goes to
   // the port not served last (round-robin) or to port 0 (fixed priority).
   always_comb begin
      // NOTE: every variable gets a default first, so no path can infer a latch.
      grant_d = req1_valid;
      if (req0_valid && req1_valid) begin
         grant_d = RR_EN ? ~last_q : 1'b0;
      end
   end

   // NOTE: rst_n gates acceptance directly, so no ready is offered while reset is held.
   assign accept     = rst_n && (state_q == IDLE) && (req0_valid || req1_valid);
   assign req0_ready = accept && !grant_d;
   assign req1_ready = accept &&  grant_d;

   assign resp_take  = grant_q ? resp1_ready : resp0_ready;

   // Operands reach the ALU only while it is evaluating; otherwise they are 0.
   assign alu_a   = (state_q == EXEC) ? a_q   : '0;
   assign alu_b   = (state_q == EXEC) ? b_q   : '0;
   assign alu_ctr = (state_q == EXEC) ? ctr_q : '0;

   assign resp0_valid = (state_q == RESP) && !grant_q;
   assign resp1_valid = (state_q == RESP) &&  grant_q;
   assign resp0_out   = resp0_valid ? res_q : '0;
   assign resp1_out   = resp1_valid ? res_q : '0;

   assign busy = (state_q != IDLE);

   // Operation sequencer: latch the granted request, capture the ALU result,
   // then hold it until the owning port takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         ctr_q   <= '0;
         res_q   <= '0;
         grant_q <= 1'b0;
         last_q  <= 1'b1;   // port 0 wins the first tie after reset
      end else begin
         // NOTE: non-blocking assignments keep all state updates simultaneous at the edge.
         case (state_q)
            IDLE: begin
               if (accept) begin
                  a_q     <= grant_d ? req1_a   : req0_a;
                  b_q     <= grant_d ? req1_b   : req0_b;
                  ctr_q   <= grant_d ? req1_ctr : req0_ctr;
                  grant_q <= grant_d;
                  last_q  <= grant_d;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               res_q   <= alu_out;
               state_q <= RESP;
            end
            RESP: begin
               if (resp_take) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model. A second instance with
// fixed priority is exercised in the arbitration scenario.
module tb_alu_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   // Round-robin instance signals
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]  req0_ctr, req1_ctr;
   logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
   logic [31:0] resp0_out, resp1_out;
   logic [31:0] alu_a, alu_b, alu_out;
   logic [3:0]  alu_ctr;
   logic        busy;

   // Fixed-priority instance signals
   logic        f_req0_valid, f_req0_ready, f_req1_valid, f_req1_ready;
   logic [31:0] f_req0_a, f_req0_b, f_req1_a, f_req1_b;
   logic [3:0]  f_req0_ctr, f_req1_ctr;
   logic        f_resp0_valid, f_resp0_ready, f_resp1_valid, f_resp1_ready;
   logic [31:0] f_resp0_out, f_resp1_out;
   logic [31:0] f_alu_a, f_alu_b, f_alu_out;
   logic [3:0]  f_alu_ctr;
   logic        f_busy;

   int total = 0;
   int bad   = 0;

   // Stand-in for the shared ALU; the arbiter never interprets the code.
   function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] c);
      case (c)
         4'b0000: return a + b;
         4'b1000: return a - b;
         4'b0011: return b;
         4'b0001: return a & b;
         4'b0010: return a | b;
         default: return a ^ b;
      endcase
   endfunction

   assign alu_out   = alu_model(alu_a, alu_b, alu_ctr);
   assign f_alu_out = alu_model(f_alu_a, f_alu_b, f_alu_ctr);

   alu_arbiter #(.RR_EN(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_ctr(req0_ctr), .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_out(resp0_out),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_ctr(req1_ctr), .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_out(resp1_out),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr), .alu_out(alu_out), .busy(busy)
   );

   alu_arbiter #(.RR_EN(1'b0)) u_fix (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_a(f_req0_a), .req0_b(f_req0_b),
      .req0_ctr(f_req0_ctr), .resp0_valid(f_resp0_valid), .resp0_ready(f_resp0_ready), .resp0_out(f_resp0_out),
      .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_a(f_req1_a), .req1_b(f_req1_b),
      .req1_ctr(f_req1_ctr), .resp1_valid(f_resp1_valid), .resp1_ready(f_resp1_ready), .resp1_out(f_resp1_out),
      .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_ctr(f_alu_ctr), .alu_out(f_alu_out), .busy(f_busy)
   );

   // Advance one full cycle; returns at the falling edge where inputs change.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
      req0_a = '0; req0_b = '0; req0_ctr = '0; req1_a = '0; req1_b = '0; req1_ctr = '0;
      f_req0_valid = 0; f_req1_valid = 0; f_resp0_ready = 0; f_resp1_ready = 0;
      f_req0_a = '0; f_req0_b = '0; f_req0_ctr = '0; f_req1_a = '0; f_req1_b = '0; f_req1_ctr = '0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 0;
      idle_inputs();
      tick();
      rst_n = 1;
   endtask

   // All outputs are 0 while reset is held, even with requests pending.
   task automatic test_reset();
      rst_n = 0;
      idle_inputs();
      req0_valid = 1; req1_valid = 1; resp0_ready = 1; resp1_ready = 1;
      f_req0_valid = 1; f_req1_valid = 1;
      req0_a = 32'h1234; req1_b = 32'h5678;
      #2;
      total++;
      if ({req0_ready, req1_ready, resp0_valid, resp1_valid, busy} !== 5'b0) begin
         bad++;
         $display("FAIL reset_ctrl got %b want 00000", {req0_ready, req1_ready, resp0_valid, resp1_valid, busy});
      end
      total++;
      if ({resp0_out, resp1_out, alu_a, alu_b, alu_ctr} !== '0) begin
         bad++;
         $display("FAIL reset_data got %h %h %h %h %h want all 0", resp0_out, resp1_out, alu_a, alu_b, alu_ctr);
      end
      total++;
      if ({f_req0_ready, f_req1_ready, f_busy} !== 3'b0) begin
         bad++;
         $display("FAIL reset_fix_ctrl got %b want 000", {f_req0_ready, f_req1_ready, f_busy});
      end
      apply_reset();
   endtask

   // Port 0 add: ready at T, result visible at T+2.
   task automatic test_single();
      req0_valid = 1; req0_a = 5; req0_b = 3; req0_ctr = 4'b0000;
      #1;
      total++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         bad++; $display("FAIL single_ready got %b want 10", {req0_ready, req1_ready});
      end
      tick();
      req0_valid = 0;
      #1;
      total++;
      if ({busy, resp0_valid, alu_a, alu_b, alu_ctr} !== {1'b1, 1'b0, 32'd5, 32'd3, 4'd0}) begin
         bad++; $display("FAIL single_exec got busy=%b v=%b a=%h b=%h c=%h want 1 0 5 3 0",
                         busy, resp0_valid, alu_a, alu_b, alu_ctr);
      end
      tick();
      #1;
      total++;
      if ({resp0_valid, resp0_out, alu_a} !== {1'b1, 32'h8, 32'h0}) begin
         bad++; $display("FAIL single_resp got v=%b out=%h alu_a=%h want 1 00000008 0", resp0_valid, resp0_out, alu_a);
      end
      resp0_ready = 1;
      tick();
      resp0_ready = 0;
      #1;
      total++;
      if ({resp0_valid, resp0_out, busy} !== {1'b0, 32'h0, 1'b0}) begin
         bad++; $display("FAIL single_done got v=%b out=%h busy=%b want 0 0 0", resp0_valid, resp0_out, busy);
      end
   endtask

   // Port 1 subtract; port 0 response must never appear.
   task automatic test_sub();
      logic r0_seen;
      r0_seen = 0;
      @(negedge clk);
      req1_valid = 1; req1_a = 3; req1_b = 5; req1_ctr = 4'b1000;
      #1;
      r0_seen |= resp0_valid;
      total++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
         bad++; $display("FAIL sub_ready got %b want 01", {req0_ready, req1_ready});
      end
      tick();
      req1_valid = 0;
      #1;
      r0_seen |= resp0_valid;
      tick();
      #1;
      r0_seen |= resp0_valid;
      total++;
      if ({resp1_valid, resp1_out} !== {1'b1, 32'hFFFF_FFFE}) begin
         bad++; $display("FAIL sub_resp got v=%b out=%h want 1 fffffffe", resp1_valid, resp1_out);
      end
      resp1_ready = 1;
      tick();
      resp1_ready = 0;
      #1;
      r0_seen |= resp0_valid;
      total++;
      if (r0_seen !== 1'b0) begin
         bad++; $display("FAIL sub_resp0_quiet got %b want 0", r0_seen);
      end
   endtask

   // Unused-looking control code passes straight through to the ALU.
   task automatic test_ctr();
      logic [31:0] a;
      a = $urandom;
      @(negedge clk);
      req0_valid = 1; req0_a = a; req0_b = 32'hDEAD_BEEF; req0_ctr = 4'b0011;
      tick();
      req0_valid = 0;
      #1;
      total++;
      if ({alu_ctr, alu_a, alu_b} !== {4'b0011, a, 32'hDEAD_BEEF}) begin
         bad++; $display("FAIL ctr_exec got c=%b a=%h b=%h want 0011 %h deadbeef", alu_ctr, alu_a, alu_b, a);
      end
      tick();
      #1;
      total++;
      if ({resp0_valid, resp0_out} !== {1'b1, 32'hDEAD_BEEF}) begin
         bad++; $display("FAIL ctr_resp got v=%b out=%h want 1 deadbeef", resp0_valid, resp0_out);
      end
      resp0_ready = 1;
      tick();
      resp0_ready = 0;
   endtask

   // Response stalled for 5 cycles blocks port 1 until the cycle after it is taken.
   task automatic test_stall();
      @(negedge clk);
      req0_valid = 1; req0_a = 10; req0_b = 20; req0_ctr = 4'b0000;
      tick();
      req0_valid = 0;
      req1_valid = 1; req1_a = 7; req1_b = 1; req1_ctr = 4'b1000;
      tick();
      for (int i = 0; i < 5; i++) begin
         #1;
         total++;
         if ({resp0_valid, resp0_out, busy, req1_ready} !== {1'b1, 32'd30, 1'b1, 1'b0}) begin
            bad++; $display("FAIL stall_hold[%0d] got v=%b out=%h busy=%b r1=%b want 1 0000001e 1 0",
                            i, resp0_valid, resp0_out, busy, req1_ready);
         end
         tick();
      end
      resp0_ready = 1;
      #1;
      total++;
      if (req1_ready !== 1'b0) begin
         bad++; $display("FAIL stall_take_cycle got r1=%b want 0", req1_ready);
      end
      tick();
      resp0_ready = 0;
      #1;
      total++;
      if ({req1_ready, resp0_valid} !== 2'b10) begin
         bad++; $display("FAIL stall_next_accept got r1=%b v0=%b want 1 0", req1_ready, resp0_valid);
      end
      tick();
      req1_valid = 0;
      tick();
      #1;
      total++;
      if ({resp1_valid, resp1_out} !== {1'b1, 32'd6}) begin
         bad++; $display("FAIL stall_resp1 got v=%b out=%h want 1 00000006", resp1_valid, resp1_out);
      end
      resp1_ready = 1;
      tick();
      resp1_ready = 0;
   endtask

   // Reset in EXEC drops the operation; the next tie goes to port 0.
   task automatic test_reset_exec();
      @(negedge clk);
      // Make port 1 the last-granted port is not needed: reset restores the pointer.
      req0_valid = 1; req0_a = 1; req0_b = 2; req0_ctr = 4'b0000;
      tick();
      req1_valid = 1; req1_a = 9; req1_b = 9; req1_ctr = 4'b0000;
      req0_a = 4; req0_b = 4;
      rst_n = 0;
      #1;
      total++;
      if ({req0_ready, req1_ready, resp0_valid, resp1_valid, busy, alu_a, alu_b, alu_ctr} !== '0) begin
         bad++; $display("FAIL rstexec_outputs got r=%b%b v=%b%b busy=%b alu=%h/%h/%h want all 0",
                         req0_ready, req1_ready, resp0_valid, resp1_valid, busy, alu_a, alu_b, alu_ctr);
      end
      tick();
      rst_n = 1;
      #1;
      total++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         bad++; $display("FAIL rstexec_tie got %b want 10", {req0_ready, req1_ready});
      end
      tick();
      req0_valid = 0; req1_valid = 0;
      #1;
      total++;
      if ({resp0_valid, resp1_valid} !== 2'b00) begin
         bad++; $display("FAIL rstexec_no_resp got %b want 00", {resp0_valid, resp1_valid});
      end
      tick();
      #1;
      total++;
      if ({resp0_valid, resp0_out, resp1_valid} !== {1'b1, 32'd8, 1'b0}) begin
         bad++; $display("FAIL rstexec_new_op got v0=%b out=%h v1=%b want 1 00000008 0",
                         resp0_valid, resp0_out, resp1_valid);
      end
      resp0_ready = 1;
      tick();
      resp0_ready = 0;
   endtask

   // Both ports always requesting from reset: RR alternates, fixed drains port 0 first.
   task automatic test_arbitration();
      int acc0, acc1, facc0, facc1;
      int order[$];
      int forder[$];
      acc0 = 0; acc1 = 0; facc0 = 0; facc1 = 0;
      apply_reset();
      for (int cyc = 0; cyc < 40; cyc++) begin
         req0_valid = (acc0 < 4); req1_valid = (acc1 < 4);
         req0_a = acc0; req0_b = 100; req0_ctr = 0;
         req1_a = acc1; req1_b = 200; req1_ctr = 0;
         resp0_ready = 1; resp1_ready = 1;
         f_req0_valid = (facc0 < 4); f_req1_valid = (facc1 < 4);
         f_req0_a = facc0; f_req0_b = 1; f_req0_ctr = 0;
         f_req1_a = facc1; f_req1_b = 2; f_req1_ctr = 0;
         f_resp0_ready = 1; f_resp1_ready = 1;
         #1;
         if (req0_ready)   begin order.push_back(0);  acc0++;  end
         if (req1_ready)   begin order.push_back(1);  acc1++;  end
         if (f_req0_ready) begin forder.push_back(0); facc0++; end
         if (f_req1_ready) begin forder.push_back(1); facc1++; end
         tick();
      end
      idle_inputs();
      total++;
      if (order.size() != 8 || forder.size() != 8) begin
         bad++; $display("FAIL arb_count got rr=%0d fix=%0d want 8 8", order.size(), forder.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            total++;
            if (order[i] != (i % 2)) begin
               bad++; $display("FAIL arb_rr[%0d] got %0d want %0d", i, order[i], i % 2);
            end
            total++;
            if (forder[i] != (i < 4 ? 0 : 1)) begin
               bad++; $display("FAIL arb_fix[%0d] got %0d want %0d", i, forder[i], (i < 4 ? 0 : 1));
            end
         end
      end
   endtask

   // Random traffic against a transaction-level model of the arbiter.
   task automatic test_random();
      bit          m_busy, m_g, m_last, g;
      int          m_age;
      logic [31:0] m_a, m_b, m_res, e_o0, e_o1;
      logic [3:0]  m_ctr;
      logic        e_r0, e_r1, e_v0, e_v1;
      logic [67:0] e_alu;
      apply_reset();
      m_busy = 0; m_g = 0; m_last = 1; m_age = 0;
      m_a = '0; m_b = '0; m_ctr = '0; m_res = '0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         req0_valid = $urandom_range(0, 1); req1_valid = $urandom_range(0, 1);
         req0_a = $urandom; req0_b = $urandom; req0_ctr = 4'($urandom_range(0, 15));
         req1_a = $urandom; req1_b = $urandom; req1_ctr = 4'($urandom_range(0, 15));
         resp0_ready = ($urandom_range(0, 3) != 0); resp1_ready = ($urandom_range(0, 3) != 0);
         #1;
         e_r0 = 0; e_r1 = 0; g = 0;
         if (!m_busy && (req0_valid || req1_valid)) begin
            g = (req0_valid && req1_valid) ? !m_last : req1_valid;
            if (g) e_r1 = 1; else e_r0 = 1;
         end
         e_v0 = m_busy && m_age == 2 && !m_g;
         e_v1 = m_busy && m_age == 2 &&  m_g;
         e_o0 = e_v0 ? m_res : '0;
         e_o1 = e_v1 ? m_res : '0;
         e_alu = (m_busy && m_age == 1) ? {m_a, m_b, m_ctr} : '0;
         total++;
         if ({req0_ready, req1_ready, resp0_valid, resp1_valid, busy} !== {e_r0, e_r1, e_v0, e_v1, m_busy}) begin
            bad++; $display("FAIL rand_ctrl[%0d] got %b want %b", cyc,
                            {req0_ready, req1_ready, resp0_valid, resp1_valid, busy}, {e_r0, e_r1, e_v0, e_v1, m_busy});
         end
         total++;
         if ({resp0_out, resp1_out} !== {e_o0, e_o1}) begin
            bad++; $display("FAIL rand_out[%0d] got %h %h want %h %h", cyc, resp0_out, resp1_out, e_o0, e_o1);
         end
         total++;
         if ({alu_a, alu_b, alu_ctr} !== e_alu) begin
            bad++; $display("FAIL rand_alu[%0d] got %h want %h", cyc, {alu_a, alu_b, alu_ctr}, e_alu);
         end
         if (!m_busy) begin
            if (e_r0 || e_r1) begin
               m_busy = 1; m_age = 1; m_g = g; m_last = g;
               m_a   = g ? req1_a   : req0_a;
               m_b   = g ? req1_b   : req0_b;
               m_ctr = g ? req1_ctr : req0_ctr;
               m_res = alu_model(m_a, m_b, m_ctr);
            end
         end else if (m_age == 1) begin
            m_age = 2;
         end else if (m_g ? resp1_ready : resp0_ready) begin
            m_busy = 0;
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_single();
      test_sub();
      test_ctr();
      test_stall();
      test_reset_exec();
      test_arbitration();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter RR_EN, default 1, where 1 selects round-robin arbitration and 0 gives port 0 fixed priority.
REQ-002 The block SHALL have port clk  input  1  system clock, with all state updating on the rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port reqN_valid  input  1  (N=0,1) request N presents an operation.
REQ-005 The block SHALL have port reqN_ready  output  1  arbiter accepts request N this cycle.
REQ-006 The block SHALL have port reqN_a, reqN_b  input  32  request N operands.
REQ-007 The block SHALL have port reqN_ctr  input  4  request N ALU control code.
REQ-008 The block SHALL have port respN_valid  output  1  result for port N is available.
REQ-009 The block SHALL have port respN_ready  input  1  port N takes its result.
REQ-010 The block SHALL have port respN_out  output  32  result for port N.
REQ-011 The block SHALL have port alu_a, alu_b  output  32  operands driven to the shared ALU instance.
REQ-012 The block SHALL have port alu_ctr  output  4  control code driven to the shared ALU.
REQ-013 The block SHALL have port alu_out  input  32  combinational ALU result.
REQ-014 The block SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, EXEC, RESP.
REQ-016 In IDLE, when any reqN_valid is high, the block SHALL pick a grant g, assert req_g_ready combinationally for exactly that cycle, latch a/b/ctr of port g, latch g, and move to EXEC.
REQ-017 In IDLE, reqN_ready SHALL be 0 for the non-granted port, and both readys SHALL be 0 in EXEC and RESP.
REQ-018 Arbitration, single valid: the block SHALL grant that port.
REQ-019 Arbitration, both valid with RR_EN=1: the block SHALL grant the port not granted last; with RR_EN=0 it SHALL grant port 0.
REQ-020 The last-grant pointer SHALL update only on an accepted request.
REQ-021 In EXEC, alu_a/alu_b/alu_ctr SHALL be driven from the latched registers; the block SHALL capture alu_out into the result register and move to RESP.
REQ-022 In IDLE and RESP, alu_a, alu_b and alu_ctr SHALL be driven to 0.
REQ-023 In RESP, the block SHALL hold resp_g_valid=1 with resp_g_out equal to the result register; resp_other_valid SHALL be 0.
REQ-024 In RESP, when resp_g_ready=1, the block SHALL return to IDLE on that edge; otherwise it SHALL hold RESP indefinitely with a stable result.
REQ-025 Latency: the block SHALL assert respN_valid on the second edge after the edge at which the request is accepted (T accept, T+2 valid).
REQ-026 Back-to-back: the block SHALL NOT accept a new request in the cycle a response is taken, giving a minimum of 3 cycles per operation.
REQ-027 respN_out SHALL be 0 whenever respN_valid=0.
REQ-028 ctr SHALL be passed unmodified; the block SHALL NOT interpret any code, including unused ones.
REQ-029 The block SHALL ignore valid deasserted without acceptance; it SHALL ignore respN_ready while respN_valid=0.

Reset
REQ-030 When rst_n=0, the block SHALL immediately force: state IDLE; operand, ctr, result and grant registers to 0; last-grant pointer to 1 (port 0 wins the first tie).
REQ-031 While rst_n=0, all outputs SHALL be 0.
REQ-032 On reset during EXEC or RESP, the block SHALL discard the in-flight operation with no response produced.
REQ-033 After rst_n rises, the block SHALL accept requests on the first clock edge.

Verification
REQ-034 Bench: req0 a=5, b=3, ctr=0000 -> req0_ready at T, resp0_valid at T+2, resp0_out=0x00000008.
REQ-035 Bench: req1 a=3, b=5, ctr=1000 -> resp1_out=0xFFFFFFFE; resp0_valid stays 0 throughout.
REQ-036 Bench: both valid from reset, 4 ops each, RR_EN=1 -> grants 0,1,0,1,...; with RR_EN=0 all four port-0 ops complete before any port-1 op.
REQ-037 Bench: resp0_ready held 0 for 5 cycles -> resp0_valid and resp0_out stable, busy=1, req1 not accepted; accepted the cycle after ready.
REQ-038 Bench: rst_n pulsed low in EXEC -> outputs 0 at once, no response, next tie grants port 0.
REQ-039 Bench: ctr=0011, b=0xDEADBEEF -> alu_ctr=0011 in EXEC, resp_out=ALU output (0xDEADBEEF).
